// File: rtl/div_unit_lane_pkg.sv
// Shared types and constants for the single-lane multi-cycle divider.
package div_unit_lane_pkg;

    localparam int unsigned DIV_DATA_WIDTH = 32;
    localparam int unsigned DIV_LATENCY    = DIV_DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'b00,
        DIV_OP_DIVU = 2'b01,
        DIV_OP_REM  = 2'b10,
        DIV_OP_REMU = 2'b11
    } div_op_e;

    // FSM encoding kept as plain constants for compatibility with older tools
    localparam logic [1:0] ST_FREE       = 2'b00;
    localparam logic [1:0] ST_PROCESSING = 2'b01;
    localparam logic [1:0] ST_FINISHED   = 2'b10;

    // DIV and REM are signed; DIVU and REMU are unsigned
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_unit_lane_if.sv
// Issue-side request and mem-stage result handshake of one divider lane.
interface div_unit_lane_if
    import div_unit_lane_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH
);
    logic                  req;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] dividend;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  flush;
    logic                  div_release;
    logic                  free;
    logic                  busy;
    logic                  finished;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output req, op, dividend, divisor, flush, div_release,
        input  free, busy, finished, data_out
    );

    modport slave (
        input  req, op, dividend, divisor, flush, div_release,
        output free, busy, finished, data_out
    );
endinterface

// File: rtl/div_unit_lane_step.sv
// One radix-2 restoring division step on unsigned magnitudes.
module div_unit_lane_step #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem,
    input  logic [DATA_WIDTH-1:0] quo,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_next,
    output logic [DATA_WIDTH-1:0] quo_next
);
    localparam int unsigned W = DATA_WIDTH;

    logic [W:0] shifted;
    logic [W:0] trial;

    // Shift the next dividend bit in, subtract, keep the result only when no borrow
    always_comb begin
        shifted = {rem, quo[W-1]};
        trial   = shifted - {1'b0, divisor};
        if (trial[W]) begin
            rem_next = shifted[W-1:0];
            quo_next = {quo[W-2:0], 1'b0};
        end else begin
            rem_next = trial[W-1:0];
            quo_next = {quo[W-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit_lane.sv
// Single-lane multi-cycle RV32M divider: FREE -> PROCESSING -> FINISHED -> release.
module div_unit_lane
    import div_unit_lane_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIV_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    div_unit_lane_if.slave bus
);
    localparam int unsigned W = DATA_WIDTH;
    localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

    logic [1:0]           state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic [W-1:0]         rem, rem_n, quo, quo_n, dvs, dvs_n;
    logic                 q_neg, q_neg_n, r_neg, r_neg_n, is_rem, is_rem_n;
    logic [W-1:0]         dout, dout_n;
    logic                 free, busy, finished;

    logic                 signed_op, a_neg, b_neg, div_zero, overflow;
    logic [W-1:0]         a_abs, b_abs, step_rem, step_quo, q_fix, r_fix;

    assign signed_op = op_is_signed(bus.op);
    assign a_neg     = signed_op & bus.dividend[W-1];
    assign b_neg     = signed_op & bus.divisor[W-1];
    assign a_abs     = a_neg ? (~bus.dividend + W'(1)) : bus.dividend;
    assign b_abs     = b_neg ? (~bus.divisor + W'(1)) : bus.divisor;
    assign div_zero  = (bus.divisor == '0);
    assign overflow  = signed_op && (bus.dividend == MOST_NEG) && (bus.divisor == '1);

    div_unit_lane_step #(.DATA_WIDTH(W)) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (dvs),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    // Sign correction applied to the last step's output so the result lands with FINISHED
    assign q_fix = q_neg ? (~step_quo + W'(1)) : step_quo;
    assign r_fix = r_neg ? (~step_rem + W'(1)) : step_rem;

    // Next-state and datapath update; flush overrides everything
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rem_n    = rem;
        quo_n    = quo;
        dvs_n    = dvs;
        q_neg_n  = q_neg;
        r_neg_n  = r_neg;
        is_rem_n = is_rem;
        dout_n   = dout;
        if (bus.flush) begin
            state_n = ST_FREE;
            cnt_n   = '0;
        end else begin
            case (state)
                ST_FREE: begin
                    if (bus.req) begin
                        is_rem_n = op_is_rem(bus.op);
                        if (div_zero) begin
                            dout_n  = op_is_rem(bus.op) ? bus.dividend : '1;
                            state_n = ST_FINISHED;
                        end else if (overflow) begin
                            dout_n  = op_is_rem(bus.op) ? '0 : bus.dividend;
                            state_n = ST_FINISHED;
                        end else begin
                            rem_n   = '0;
                            quo_n   = a_abs;
                            dvs_n   = b_abs;
                            q_neg_n = a_neg ^ b_neg;
                            r_neg_n = a_neg;
                            cnt_n   = CNT_WIDTH'(W);
                            state_n = ST_PROCESSING;
                        end
                    end
                end
                ST_PROCESSING: begin
                    rem_n = step_rem;
                    quo_n = step_quo;
                    cnt_n = cnt - CNT_WIDTH'(1);
                    if (cnt == CNT_WIDTH'(1)) begin
                        dout_n  = is_rem ? r_fix : q_fix;
                        state_n = ST_FINISHED;
                    end
                end
                ST_FINISHED: begin
                    if (bus.div_release) begin
                        state_n = ST_FREE;
                    end
                end
                default: state_n = ST_FREE;
            endcase
        end
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_FREE;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            is_rem   <= 1'b0;
            dout     <= '0;
            free     <= 1'b1;
            busy     <= 1'b0;
            finished <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            quo      <= quo_n;
            dvs      <= dvs_n;
            q_neg    <= q_neg_n;
            r_neg    <= r_neg_n;
            is_rem   <= is_rem_n;
            dout     <= dout_n;
            free     <= (state_n == ST_FREE);
            busy     <= (state_n == ST_PROCESSING);
            finished <= (state_n == ST_FINISHED);
        end
    end

    assign bus.free     = free;
    assign bus.busy     = busy;
    assign bus.finished = finished;
    assign bus.data_out = dout;

    // Issue logic must only request while the lane is free
    req_only_when_free: assert property (@(posedge clk) disable iff (!rst_n) bus.req |-> free);

endmodule

// File: tb/tb_div_unit_lane.sv
// Self-checking bench for div_unit_lane: directed corner cases plus randomized ops.
module tb_div_unit_lane;
    import div_unit_lane_pkg::*;

    localparam int unsigned W = 32;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cur_lat;

    div_unit_lane_if #(.DATA_WIDTH(W)) bus ();

    div_unit_lane #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference model in plain arithmetic following RISC-V M semantics
    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic sgn;
        logic rem;
        sgn = (op == 2'b00) || (op == 2'b10);
        rem = (op == 2'b10) || (op == 2'b11);
        if (b == 0) return rem ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rem ? 32'h0 : a;
            return rem ? W'($signed(a) % $signed(b)) : W'($signed(a) / $signed(b));
        end
        return rem ? (a % b) : (a / b);
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic sgn;
        sgn = (op == 2'b00) || (op == 2'b10);
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_LATENCY;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        #1;
        cur_lat++;
    endtask

    // Present a request for one cycle; afterwards we are in the cycle after acceptance
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        bus.req      = 1'b1;
        bus.op       = op;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        #1;
        bus.req = 1'b0;
        cur_lat = 1;
    endtask

    task automatic finish_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        while (!bus.finished && cur_lat < 80) step_cycle();
        check({tag, "_lat"}, W'(cur_lat), W'(ref_latency(op, a, b)));
        check({tag, "_data"}, bus.data_out, ref_result(op, a, b));
    endtask

    task automatic release_op(input string tag);
        @(negedge clk);
        bus.div_release = 1'b1;
        @(posedge clk);
        #1;
        bus.div_release = 1'b0;
        check({tag, "_rel_free"}, W'(bus.free), W'(1));
        check({tag, "_rel_fin"}, W'(bus.finished), W'(0));
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(op, a, b);
        finish_op(tag, op, a, b);
        release_op(tag);
    endtask

    initial begin
        logic [W-1:0] saved;
        logic         hold_ok;
        logic [1:0]   rop;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           sel;

        tests           = 0;
        fails           = 0;
        cur_lat         = 0;
        rst_n           = 1'b0;
        bus.req         = 1'b0;
        bus.op          = 2'b00;
        bus.dividend    = '0;
        bus.divisor     = '0;
        bus.flush       = 1'b0;
        bus.div_release = 1'b0;

        #12;
        check("reset_free", W'(bus.free), W'(1));
        check("reset_busy", W'(bus.busy), W'(0));
        check("reset_fin", W'(bus.finished), W'(0));
        check("reset_data", bus.data_out, W'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the divider's corner list
        run_op("divu_100_7", 2'b01, 32'd100, 32'd7);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE);
        run_op("div_5_0", 2'b00, 32'd5, 32'd0);
        run_op("remu_5_0", 2'b11, 32'd5, 32'd0);
        run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1);

        // Result held without release
        start_op(2'b01, 32'd100, 32'd7);
        finish_op("hold", 2'b01, 32'd100, 32'd7);
        saved   = bus.data_out;
        hold_ok = 1'b1;
        repeat (20) begin
            step_cycle();
            if (!bus.finished || bus.data_out !== saved) hold_ok = 1'b0;
        end
        check("hold_stable", W'(hold_ok), W'(1));
        release_op("hold");

        // Flush mid-operation, then a fresh request in the following cycle
        start_op(2'b01, 32'd100, 32'd7);
        repeat (9) step_cycle();
        @(negedge clk);
        bus.flush = 1'b1;
        step_cycle();
        check("flush_free", W'(bus.free), W'(1));
        check("flush_busy", W'(bus.busy), W'(0));
        check("flush_fin", W'(bus.finished), W'(0));
        @(negedge clk);
        bus.flush = 1'b0;
        run_op("after_flush", 2'b00, 32'hFFFF_FF9C, 32'd7);

        // Flush together with req in FREE drops the req
        @(negedge clk);
        bus.req      = 1'b1;
        bus.flush    = 1'b1;
        bus.op       = 2'b01;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        @(posedge clk);
        #1;
        bus.req   = 1'b0;
        bus.flush = 1'b0;
        check("flushreq_free", W'(bus.free), W'(1));
        check("flushreq_busy", W'(bus.busy), W'(0));

        // Flush together with release in FINISHED
        start_op(2'b01, 32'd5, 32'd0);
        finish_op("flushrel", 2'b01, 32'd5, 32'd0);
        @(negedge clk);
        bus.flush       = 1'b1;
        bus.div_release = 1'b1;
        step_cycle();
        bus.flush       = 1'b0;
        bus.div_release = 1'b0;
        check("flushrel_free", W'(bus.free), W'(1));
        check("flushrel_fin", W'(bus.finished), W'(0));

        // Release while processing is ignored
        start_op(2'b10, 32'd1000, 32'd33);
        @(negedge clk);
        bus.div_release = 1'b1;
        step_cycle();
        bus.div_release = 1'b0;
        check("early_rel_busy", W'(bus.busy), W'(1));
        finish_op("early_rel", 2'b10, 32'd1000, 32'd33);
        release_op("early_rel");

        // Asynchronous reset mid-operation
        start_op(2'b01, 32'd100, 32'd7);
        repeat (5) step_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_free", W'(bus.free), W'(1));
        check("arst_busy", W'(bus.busy), W'(0));
        check("arst_fin", W'(bus.finished), W'(0));
        check("arst_data", bus.data_out, W'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 2'b11, 32'd12345, 32'd100);

        // Randomized operations biased toward corner operands
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = 32'd0;
                1: begin
                    rb = 32'hFFFF_FFFF;
                    if ($urandom_range(0, 1) == 1) ra = 32'h8000_0000;
                end
                2: rb = 32'($urandom_range(1, 15));
                3: rb = 32'd0 - 32'($urandom_range(1, 15));
                4: begin
                    ra = 32'($urandom_range(0, 200));
                    rb = 32'($urandom_range(1, 300));
                end
                default: rb = $urandom;
            endcase
            run_op("rand", rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/div_unit_lane.md
Name: div_unit_lane

Overview:
- Single-lane multi-cycle integer divider; the producer side of the divider handshake consumed by the memory access stage (divFinished / divDataOut / divRelease).
- Accepts one RV32M DIV/DIVU/REM/REMU op from the issue path, iterates radix-2 restoring division, then holds the result with finished asserted until the memory access stage releases it.
- One instance per mem lane, instantiated inside MulDivUnit when the unified muldiv/mem pipe is configured.

Parameters:
- DATA_WIDTH, 32, operand/result width in bits; must be even, >= 4.
- CNT_WIDTH, $clog2(DATA_WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- req  in  1  start request; honoured only when free=1.
- op  in  2  DivOpCode: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  in  DATA_WIDTH  rs1 value.
- divisor  in  DATA_WIDTH  rs2 value.
- flush  in  1  cancel in-flight op (selective flush hit on owner).
- release  in  1  consumer has taken the result (divRelease).
- free  out  1  FSM in FREE; issue queue may issue a div.
- busy  out  1  FSM in PROCESSING.
- finished  out  1  FSM in FINISHED; data_out valid.
- data_out  out  DATA_WIDTH  quotient or remainder.

Behaviour:
- Reset: state=FREE, free=1, busy=0, finished=0, data_out=0, counter=0. Async assertion aborts any op immediately.
- States: FREE, PROCESSING, FINISHED.
  - FREE -> PROCESSING on req && !flush: latch |dividend|, |divisor| (abs only when op signed), quotient sign = sign(a) xor sign(b), remainder sign = sign(a), op, counter=DATA_WIDTH.
  - FREE -> FINISHED on req && !flush when a special case applies; result is loaded directly.
  - PROCESSING: one restoring step per cycle.
    - rem' = {rem[W-2:0], quo[W-1]} - divisor when non-negative, else unchanged shift; quotient LSB = borrow-free bit.
    - counter decrements; at counter==1 the next state is FINISHED and data_out gets the sign-corrected quotient or remainder.
  - FINISHED: finished=1, data_out stable; release -> FREE.
- Latency: req accepted at edge t; finished=1 from t+DATA_WIDTH+1 (t+33 for 32-bit); special cases finished=1 at t+1.
- Special cases, RISC-V semantics:
  - divisor==0: quotient = all ones, remainder = dividend (raw, unsigned view).
  - Signed op with dividend = most-negative and divisor = -1: quotient = dividend, remainder = 0.
- Sign correction: two's-complement negate in DATA_WIDTH bits; no extra width beyond DATA_WIDTH+1 for the partial remainder.
- flush: in any state -> FREE next edge; finished/busy drop. Flush dominates req and release in the same cycle; that req is dropped.
- release outside FINISHED: ignored. req outside FREE: ignored; simulation assertion fires.
- release and req in the same cycle while FINISHED: req is ignored (free still 0); back-to-back issue needs one FREE cycle.
- data_out holds its last value outside FINISHED; consumers qualify with finished.

Decomposition:
- Shared package (MulDivTypes): DivOpCode enum, DIV_LATENCY constant (DATA_WIDTH+1), DivUnitState enum.
- Optional sub-module div_step: one combinational restoring step (rem, quo, divisor -> rem', quo'). Keeps the FSM file readable and allows unrolling to radix-4 later.

Test Plan:
- DIVU 100/7 at t -> finished=1 at t+33, data_out=14; REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> 0xFFFFFFFD.
- DIV 5/0 -> finished at t+1, data_out=0xFFFFFFFF; REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> finished at t+1, data_out=0x80000000; REM -> 0.
- Flush: flush at t+10 during DIVU 100/7 -> free=1 at t+11, finished never asserts; new req at t+11 completes normally at t+44.
- Hold/reset: no release for 20 cycles -> finished and data_out stable. Release -> free next cycle. rst_n low mid-PROCESSING -> all outputs at reset values immediately.
